// File: rtl/e_pipe_reg_pkg.sv
// Shared constants for the D/E pipeline register.
// Contents:
//   NOP_INSTR        - bubble instruction word (sll $0,$0,0)
//   RESET_PC_DEFAULT - default PC loaded on reset and bubble
//   TNEW_W           - width of the hazard Tnew field
//   TNEW_E_DEC       - Tnew decrement applied when moving from D to E
//   tnew_sat_dec()   - Tnew decrement saturating at zero
package e_pipe_reg_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int unsigned        TNEW_W     = 2;
  localparam logic [TNEW_W-1:0]  TNEW_E_DEC = 2'd1;

  // An instruction already producing its result in D stays at 0 in E.
  function automatic logic [TNEW_W-1:0] tnew_sat_dec(input logic [TNEW_W-1:0] tnew);
    return (tnew >= TNEW_E_DEC) ? (tnew - TNEW_E_DEC) : '0;
  endfunction

endpackage

// File: rtl/e_pipe_reg_if.sv
// Bundle between the D stage, the D/E register and the E stage.
// Modports:
//   master - D-stage side: drives en/clr and the D_* bundle, observes E_*
//   slave  - the register: consumes en/clr and D_*, drives E_*
// With E_PIPE_STAT_EN defined the bundle also carries the bubble and
// instruction counters E_bubble_cnt / E_instr_cnt.
interface e_pipe_reg_if
  import e_pipe_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic              en;
  logic              clr;
  logic [31:0]       D_instr;
  logic [WIDTH-1:0]  D_pc;
  logic [WIDTH-1:0]  D_rs_val;
  logic [WIDTH-1:0]  D_rt_val;
  logic [WIDTH-1:0]  D_ext;
  logic [TNEW_W-1:0] D_tnew;

  logic [31:0]       E_instr;
  logic [WIDTH-1:0]  E_pc;
  logic [WIDTH-1:0]  E_rs_val;
  logic [WIDTH-1:0]  E_rt_val;
  logic [WIDTH-1:0]  E_ext;
  logic [TNEW_W-1:0] E_tnew;
  logic              E_valid;
`ifdef E_PIPE_STAT_EN
  logic [31:0]       E_bubble_cnt;
  logic [31:0]       E_instr_cnt;
`endif

  modport master (
    output en, clr, D_instr, D_pc, D_rs_val, D_rt_val, D_ext, D_tnew,
    input  E_instr, E_pc, E_rs_val, E_rt_val, E_ext, E_tnew, E_valid
`ifdef E_PIPE_STAT_EN
    , input E_bubble_cnt, E_instr_cnt
`endif
  );

  modport slave (
    input  en, clr, D_instr, D_pc, D_rs_val, D_rt_val, D_ext, D_tnew,
    output E_instr, E_pc, E_rs_val, E_rt_val, E_ext, E_tnew, E_valid
`ifdef E_PIPE_STAT_EN
    , output E_bubble_cnt, E_instr_cnt
`endif
  );

endinterface

// File: rtl/e_pipe_reg_pipe_field_reg.sv
// pipe_field_reg: one field of the D/E pipeline register.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, loads RST_VAL
//   en    - 1 = capture d, 0 = hold
//   clr   - 1 = load CLR_VAL, overrides en
//   d     - next value
//   q     - registered value
module pipe_field_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = CLR_VAL;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/e_pipe_reg.sv
// e_pipe_reg: D/E pipeline register feeding the E-stage ALU and hazard logic.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - e_pipe_reg_if.slave: en/clr control, D_* bundle in, E_* bundle out
// Priority per edge: reset > clr (bubble) > en = 0 (hold) > capture.
// Optional feature macro E_PIPE_STAT_EN adds E_bubble_cnt / E_instr_cnt.
module e_pipe_reg
  import e_pipe_reg_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT[WIDTH-1:0]
) (
  input logic         clk,
  input logic         reset,
  e_pipe_reg_if.slave bus
);

  logic [TNEW_W-1:0] tnew_e;

  assign tnew_e = tnew_sat_dec(bus.D_tnew);

  pipe_field_reg #(.WIDTH(32), .RST_VAL(NOP_INSTR), .CLR_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .reset(reset), .en(bus.en), .clr(bus.clr), .d(bus.D_instr), .q(bus.E_instr)
  );

  pipe_field_reg #(.WIDTH(WIDTH), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(bus.en), .clr(bus.clr), .d(bus.D_pc), .q(bus.E_pc)
  );

  pipe_field_reg #(.WIDTH(WIDTH)) u_rs_val (
    .clk(clk), .reset(reset), .en(bus.en), .clr(bus.clr), .d(bus.D_rs_val), .q(bus.E_rs_val)
  );

  pipe_field_reg #(.WIDTH(WIDTH)) u_rt_val (
    .clk(clk), .reset(reset), .en(bus.en), .clr(bus.clr), .d(bus.D_rt_val), .q(bus.E_rt_val)
  );

  pipe_field_reg #(.WIDTH(WIDTH)) u_ext (
    .clk(clk), .reset(reset), .en(bus.en), .clr(bus.clr), .d(bus.D_ext), .q(bus.E_ext)
  );

  pipe_field_reg #(.WIDTH(TNEW_W)) u_tnew (
    .clk(clk), .reset(reset), .en(bus.en), .clr(bus.clr), .d(tnew_e), .q(bus.E_tnew)
  );

  // Valid marks capture versus bubble only; a captured all-zero word is still valid.
  pipe_field_reg #(.WIDTH(1)) u_valid (
    .clk(clk), .reset(reset), .en(bus.en), .clr(bus.clr), .d(1'b1), .q(bus.E_valid)
  );

`ifdef E_PIPE_STAT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] instr_cnt_d, instr_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    if (bus.clr) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (bus.en) begin
      instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      instr_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign bus.E_bubble_cnt = bubble_cnt_q;
  assign bus.E_instr_cnt  = instr_cnt_q;
`endif

endmodule

// File: tb/tb_e_pipe_reg.sv
// Directed testbench for e_pipe_reg. Counter checks are built only with E_PIPE_STAT_EN.
module tb_e_pipe_reg;

  localparam int unsigned WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;

  e_pipe_reg_if #(.WIDTH(WIDTH)) bus ();

  e_pipe_reg #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] ext, input logic [1:0] tnew);
    bus.D_instr  = instr;
    bus.D_pc     = pc;
    bus.D_rs_val = rs;
    bus.D_rt_val = rt;
    bus.D_ext    = ext;
    bus.D_tnew   = tnew;
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (bus.E_instr !== 32'h0) $display("FAIL reset_instr: got %h exp %h", bus.E_instr, 32'h0); else passed++;
    total++; if (bus.E_pc !== RESET_PC) $display("FAIL reset_pc: got %h exp %h", bus.E_pc, RESET_PC); else passed++;
    total++; if (bus.E_rs_val !== 32'h0) $display("FAIL reset_rs: got %h exp 0", bus.E_rs_val); else passed++;
    total++; if (bus.E_rt_val !== 32'h0) $display("FAIL reset_rt: got %h exp 0", bus.E_rt_val); else passed++;
    total++; if (bus.E_ext !== 32'h0) $display("FAIL reset_ext: got %h exp 0", bus.E_ext); else passed++;
    total++; if (bus.E_tnew !== 2'd0) $display("FAIL reset_tnew: got %0d exp 0", bus.E_tnew); else passed++;
    total++; if (bus.E_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus.E_valid); else passed++;
  endtask

  task automatic test_capture();
    bus.en = 1'b1; bus.clr = 1'b0;
    drive(32'h3421_0005, 32'h0000_3004, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0005, 2'd2);
    step();
    total++; if (bus.E_instr !== 32'h3421_0005) $display("FAIL cap_instr: got %h exp 34210005", bus.E_instr); else passed++;
    total++; if (bus.E_pc !== 32'h0000_3004) $display("FAIL cap_pc: got %h exp 00003004", bus.E_pc); else passed++;
    total++; if (bus.E_rs_val !== 32'h1234_5678) $display("FAIL cap_rs: got %h exp 12345678", bus.E_rs_val); else passed++;
    total++; if (bus.E_rt_val !== 32'h9ABC_DEF0) $display("FAIL cap_rt: got %h exp 9abcdef0", bus.E_rt_val); else passed++;
    total++; if (bus.E_ext !== 32'h0000_0005) $display("FAIL cap_ext: got %h exp 00000005", bus.E_ext); else passed++;
    total++; if (bus.E_tnew !== 2'd1) $display("FAIL cap_tnew: got %0d exp 1", bus.E_tnew); else passed++;
    total++; if (bus.E_valid !== 1'b1) $display("FAIL cap_valid: got %b exp 1", bus.E_valid); else passed++;
  endtask

  task automatic test_tnew_sat();
    bus.en = 1'b1; bus.clr = 1'b0;
    drive(32'h0000_0000, 32'h0000_3008, 32'h1, 32'h2, 32'h3, 2'd0);
    step();
    total++; if (bus.E_tnew !== 2'd0) $display("FAIL tnew_sat0: got %0d exp 0", bus.E_tnew); else passed++;
    // A zero instruction word that was captured is still a real instruction.
    total++; if (bus.E_valid !== 1'b1) $display("FAIL zero_instr_valid: got %b exp 1", bus.E_valid); else passed++;
    bus.D_tnew = 2'd3;
    step();
    total++; if (bus.E_tnew !== 2'd2) $display("FAIL tnew_sat3: got %0d exp 2", bus.E_tnew); else passed++;
  endtask

  task automatic test_hold();
    bus.en = 1'b1; bus.clr = 1'b0;
    drive(32'hAAAA_5555, 32'h0000_3040, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 2'd3);
    step();
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'hDEAD_0000 + i, 32'h0000_4000 + i, 32'hBEEF_0000 + i, 32'hCAFE_0000 + i,
            32'hF00D_0000 + i, 2'(i));
      step();
      total++; if (bus.E_instr !== 32'hAAAA_5555) $display("FAIL hold_instr[%0d]: got %h exp aaaa5555", i, bus.E_instr); else passed++;
      total++; if (bus.E_pc !== 32'h0000_3040) $display("FAIL hold_pc[%0d]: got %h exp 00003040", i, bus.E_pc); else passed++;
      total++; if (bus.E_rs_val !== 32'h1111_1111) $display("FAIL hold_rs[%0d]: got %h exp 11111111", i, bus.E_rs_val); else passed++;
      total++; if (bus.E_rt_val !== 32'h2222_2222) $display("FAIL hold_rt[%0d]: got %h exp 22222222", i, bus.E_rt_val); else passed++;
      total++; if (bus.E_ext !== 32'h3333_3333) $display("FAIL hold_ext[%0d]: got %h exp 33333333", i, bus.E_ext); else passed++;
      total++; if (bus.E_tnew !== 2'd2) $display("FAIL hold_tnew[%0d]: got %0d exp 2", i, bus.E_tnew); else passed++;
      total++; if (bus.E_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b exp 1", i, bus.E_valid); else passed++;
    end
  endtask

  task automatic test_bubble();
    bus.en = 1'b0; bus.clr = 1'b1;
    drive(32'h0000_0021, 32'h0000_3050, 32'h7, 32'h8, 32'h9, 2'd3);
    step();
    total++; if (bus.E_instr !== 32'h0) $display("FAIL bub_instr: got %h exp 0", bus.E_instr); else passed++;
    total++; if (bus.E_valid !== 1'b0) $display("FAIL bub_valid: got %b exp 0", bus.E_valid); else passed++;
    total++; if (bus.E_pc !== 32'h0000_3000) $display("FAIL bub_pc: got %h exp 00003000", bus.E_pc); else passed++;
    total++; if (bus.E_rs_val !== 32'h0) $display("FAIL bub_rs: got %h exp 0", bus.E_rs_val); else passed++;
    total++; if (bus.E_tnew !== 2'd0) $display("FAIL bub_tnew: got %0d exp 0", bus.E_tnew); else passed++;
    // clr with en = 1 is also a bubble.
    bus.en = 1'b1;
    step();
    total++; if (bus.E_valid !== 1'b0) $display("FAIL bub_en_valid: got %b exp 0", bus.E_valid); else passed++;
    bus.clr = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.en = 1'b1; bus.clr = 1'b0;
    drive(32'h0000_1234, 32'h0000_3010, 32'h5, 32'h6, 32'h7, 2'd2);
    step();
    total++; if (bus.E_pc !== 32'h0000_3010) $display("FAIL pre_rst_pc: got %h exp 00003010", bus.E_pc); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (bus.E_pc !== 32'h0000_3000) $display("FAIL arst_pc: got %h exp 00003000", bus.E_pc); else passed++;
    total++; if (bus.E_instr !== 32'h0) $display("FAIL arst_instr: got %h exp 0", bus.E_instr); else passed++;
    total++; if (bus.E_valid !== 1'b0) $display("FAIL arst_valid: got %b exp 0", bus.E_valid); else passed++;
    step();
    total++; if (bus.E_valid !== 1'b0) $display("FAIL rst_held_valid: got %b exp 0", bus.E_valid); else passed++;
    #2 reset = 1'b0;
    drive(32'h0000_0055, 32'h0000_3014, 32'h0, 32'h0, 32'h0, 2'd1);
    step();
    total++; if (bus.E_instr !== 32'h0000_0055) $display("FAIL post_rst_instr: got %h exp 00000055", bus.E_instr); else passed++;
    total++; if (bus.E_valid !== 1'b1) $display("FAIL post_rst_valid: got %b exp 1", bus.E_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    bus.en = 1'b1; bus.clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0100_0000 * (i + 1), 32'h0000_3100 + 4 * i, 32'h0, 32'h0, 32'h0, 2'd1);
      step();
      total++; if (bus.E_instr !== 32'h0100_0000 * (i + 1)) $display("FAIL b2b_instr[%0d]: got %h exp %h", i, bus.E_instr, 32'h0100_0000 * (i + 1)); else passed++;
      total++; if (bus.E_pc !== 32'h0000_3100 + 4 * i) $display("FAIL b2b_pc[%0d]: got %h exp %h", i, bus.E_pc, 32'h0000_3100 + 4 * i); else passed++;
    end
  endtask

  task automatic test_stats();
`ifdef E_PIPE_STAT_EN
    #2 reset = 1'b1;
    #1;
    total++; if (bus.E_instr_cnt !== 32'd0) $display("FAIL stat_rst_instr: got %0d exp 0", bus.E_instr_cnt); else passed++;
    total++; if (bus.E_bubble_cnt !== 32'd0) $display("FAIL stat_rst_bubble: got %0d exp 0", bus.E_bubble_cnt); else passed++;
    #2 reset = 1'b0;
    // capture, capture, clr, hold, capture
    bus.en = 1'b1; bus.clr = 1'b0; step();
    step();
    bus.clr = 1'b1; step();
    bus.clr = 1'b0; bus.en = 1'b0; step();
    bus.en = 1'b1; step();
    total++; if (bus.E_instr_cnt !== 32'd3) $display("FAIL stat_instr: got %0d exp 3", bus.E_instr_cnt); else passed++;
    total++; if (bus.E_bubble_cnt !== 32'd1) $display("FAIL stat_bubble: got %0d exp 1", bus.E_bubble_cnt); else passed++;
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.instr_cnt_q;
    step();
    total++; if (bus.E_instr_cnt !== 32'd0) $display("FAIL stat_wrap: got %h exp 0", bus.E_instr_cnt); else passed++;
`endif
  endtask

  initial begin
    reset   = 1'b1;
    bus.en  = 1'b0;
    bus.clr = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    #2;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_capture();
    test_tnew_sat();
    test_hold();
    test_bubble();
    test_async_reset();
    test_back_to_back();
    test_stats();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
